mult_bcd_conv: RTL and testbench

Downstream result stage for the 4x4 shift-add multiplier. It watches the multiplier's `done` level and captures the 8-bit product on each rising edge. It converts the product to three BCD digits with a sequential double-dabble (shift-add-3) engine, then holds the digits for the display driver. One pending request is buffered so back-to-back multiplications are not lost.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_bcd_conv_dd_add3.sv | 17 +
 rtl/mult_bcd_conv.sv | 125 ++++++++++++
 tb/tb_mult_bcd_conv.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the multiplier result stage
package mult_pkg;

  // Product width (also the double-dabble iteration count) and BCD digit count
  localparam int W_DEF  = 8;
  localparam int ND_DEF = 3;

  // One packed BCD digit
  typedef logic [3:0] bcd_digit_t;

  // Conversion engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADJ   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } conv_state_t;

endpackage

// File: rtl/mult_bcd_conv_dd_add3.sv
// rtl/mult_bcd_conv_dd_add3.sv - double-dabble digit correction (add 3 when >= 5)
module dd_add3
  import mult_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Digits 5..9 become 8..12, so the following shift carries into the next digit
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/mult_bcd_conv.sv
// rtl/mult_bcd_conv.sv - captures multiplier products and converts them to BCD digits
module mult_bcd_conv
  import mult_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int ND = ND_DEF
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         done,
  input  logic [W-1:0] product,
  output logic [3:0]   hundreds,
  output logic [3:0]   tens,
  output logic [3:0]   ones,
  output logic         bcd_valid,
  output logic         busy,
  output logic         overrun
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  conv_state_t       state;
  logic              done_q;
  logic              req;
  logic [W-1:0]      bin_sr;
  logic [ND*4-1:0]   bcd_sr;
  logic [ND*4-1:0]   bcd_adj;
  logic [CW-1:0]     cnt;
  logic              pend_valid;
  logic [W-1:0]      pend_product;

  // done_q resets high so a done level already present at reset release is ignored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= 1'b1;
    end else begin
      done_q <= done;
    end
  end

  assign req  = done & ~done_q;
  assign busy = (state != ST_IDLE);

  // One correction cell per scratch digit for the ADJ step
  for (genvar g = 0; g < ND; g++) begin : g_add3
    dd_add3 u_add3 (
      .din  (bcd_sr[g*4 +: 4]),
      .dout (bcd_adj[g*4 +: 4])
    );
  end

  // Conversion FSM, pending buffer and registered digit outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      bin_sr       <= '0;
      bcd_sr       <= '0;
      cnt          <= '0;
      pend_valid   <= 1'b0;
      pend_product <= '0;
      hundreds     <= 4'd0;
      tens         <= 4'd0;
      ones         <= 4'd0;
      bcd_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            // Buffered request wins; a simultaneous new request takes its slot
            bin_sr     <= pend_product;
            bcd_sr     <= '0;
            cnt        <= '0;
            state      <= ST_ADJ;
            pend_valid <= req;
            if (req) begin
              pend_product <= product;
            end
          end else if (req) begin
            bin_sr <= product;
            bcd_sr <= '0;
            cnt    <= '0;
            state  <= ST_ADJ;
          end
        end
        ST_ADJ: begin
          bcd_sr <= bcd_adj;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_sr <= {bcd_sr[ND*4-2:0], bin_sr[W-1]};
          bin_sr <= {bin_sr[W-2:0], 1'b0};
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state <= ST_FIN;
          end else begin
            state <= ST_ADJ;
          end
        end
        ST_FIN: begin
          hundreds  <= bcd_sr[8 +: 4];
          tens      <= bcd_sr[4 +: 4];
          ones      <= bcd_sr[0 +: 4];
          bcd_valid <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      // Requests arriving mid-conversion are buffered; latest one wins
      if (state != ST_IDLE && req) begin
        pend_product <= product;
        pend_valid   <= 1'b1;
        if (pend_valid) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_bcd_conv.sv
// tb/tb_mult_bcd_conv.sv - scoreboard bench for mult_bcd_conv
module tb_mult_bcd_conv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic [7:0] product;
  logic [3:0] hundreds, tens, ones;
  logic       bcd_valid, busy, overrun;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  logic [11:0] exp_q[$];

  mult_bcd_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .done      (done),
    .product   (product),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] bcd_of(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Scoreboard: every bcd_valid pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bcd_valid === 1'b1) begin
      valid_cnt      = valid_cnt + 1;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_unexpected: got %h/%h/%h, required no bcd_valid", hundreds, tens, ones);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({hundreds, tens, ones} !== e)
          $display("FAIL scoreboard_digits: got %h/%h/%h, required %h/%h/%h",
                   hundreds, tens, ones, e[11:8], e[7:4], e[3:0]);
        else
          passed = passed + 1;
      end
    end
  end

  // Drive a done level for hi cycles starting at the current negedge
  task automatic drive_req(input logic [7:0] p, input int hi, input bit expect_result);
    product = p;
    done    = 1'b1;
    if (expect_result) exp_q.push_back(bcd_of(int'(p)));
    repeat (hi) @(negedge clk);
    done = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; done = 1'b1; product = 8'h33;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({hundreds, tens, ones} !== 12'h000) $display("FAIL reset_digits: got %h, required 000", {hundreds, tens, ones}); else passed++;
    checks++; if ({bcd_valid, busy, overrun} !== 3'b000) $display("FAIL reset_flags: got %b, required 000", {bcd_valid, busy, overrun}); else passed++;
    repeat (30) @(negedge clk);
    checks++; if (valid_cnt !== 0) $display("FAIL reset_done_high: got %0d valids, required 0", valid_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_done_high_busy: got %b, required 0", busy); else passed++;
    done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n = 0;
    bit seen = 0;
    drive_req(8'hE1, 0, 1'b1);
    done = 1'b1;
    while (!seen && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (n == 2) done = 1'b0;
      if (n == 1) begin
        checks++; if (busy !== 1'b1) $display("FAIL basic_busy_start: got %b, required 1", busy); else passed++;
      end
      if (n == 17) begin
        checks++; if ({busy, bcd_valid} !== 2'b10) $display("FAIL basic_fin_cycle: got busy/valid %b, required 10", {busy, bcd_valid}); else passed++;
      end
      if (bcd_valid === 1'b1) seen = 1;
    end
    checks++; if (n != 18) $display("FAIL basic_latency: got %0d edges, required 18", n); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_after_fin: got %b, required 0", busy); else passed++;
    @(negedge clk);
    checks++; if (bcd_valid !== 1'b0) $display("FAIL basic_pulse_width: got %b, required 0", bcd_valid); else passed++;
    checks++; if ({hundreds, tens, ones} !== 12'h225) $display("FAIL basic_hold: got %h, required 225", {hundreds, tens, ones}); else passed++;
  endtask

  task automatic test_sequence;
    logic [7:0] vals [3] = '{8'h00, 8'h64, 8'h09};
    bit ok;
    for (int i = 0; i < 3; i++) begin
      drive_req(vals[i], 3, 1'b1);
      wait_drain(ok);
      checks++; if (!ok) $display("FAIL seq_drain_%0d: got timeout, required completion", i); else passed++;
      repeat (5) @(negedge clk);
      checks++;
      if ({hundreds, tens, ones} !== bcd_of(int'(vals[i])))
        $display("FAIL seq_hold_%0d: got %h, required %h", i, {hundreds, tens, ones}, bcd_of(int'(vals[i])));
      else passed++;
    end
  endtask

  task automatic test_done_held;
    int v0 = valid_cnt;
    bit ok;
    drive_req(8'h2A, 40, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL held_drain: got timeout, required completion"); else passed++;
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL held_count: got %0d valids, required 1", valid_cnt - v0); else passed++;
    checks++; if ({hundreds, tens, ones} !== 12'h042) $display("FAIL held_digits: got %h, required 042", {hundreds, tens, ones}); else passed++;
  endtask

  task automatic test_back_to_back;
    int v0 = valid_cnt;
    bit ok;
    drive_req(8'hE1, 2, 1'b1);
    repeat (3) @(negedge clk);
    drive_req(8'h51, 2, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL b2b_drain: got timeout, required completion"); else passed++;
    checks++; if (valid_cnt - v0 !== 2) $display("FAIL b2b_count: got %0d valids, required 2", valid_cnt - v0); else passed++;
    checks++; if (last_valid_cyc - prev_valid_cyc !== 18) $display("FAIL b2b_spacing: got %0d cycles, required 18", last_valid_cyc - prev_valid_cyc); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b, required 0", overrun); else passed++;
  endtask

  task automatic test_overrun;
    int v0 = valid_cnt;
    bit ok;
    drive_req(8'hE1, 2, 1'b1);
    repeat (3) @(negedge clk);
    drive_req(8'h51, 2, 1'b0);
    repeat (3) @(negedge clk);
    drive_req(8'h90, 2, 1'b1);
    wait_drain(ok);
    checks++; if (!ok) $display("FAIL ovr_drain: got timeout, required completion"); else passed++;
    checks++; if (valid_cnt - v0 !== 2) $display("FAIL ovr_count: got %0d valids, required 2", valid_cnt - v0); else passed++;
    repeat (20) @(negedge clk);
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b, required 1", overrun); else passed++;
  endtask

  task automatic test_reset_mid;
    int v0;
    bit ok;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) $display("FAIL mid_overrun_clear: got %b, required 0", overrun); else passed++;
    v0 = valid_cnt;
    drive_req(8'hE1, 2, 1'b0);
    repeat (3) @(negedge clk);
    drive_req(8'h51, 2, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({hundreds, tens, ones, busy, overrun} !== 14'h0) $display("FAIL mid_outputs: got %h busy %b ovr %b, required 0", {hundreds, tens, ones}, busy, overrun); else passed++;
    repeat (40) @(negedge clk);
    checks++; if (valid_cnt !== v0) $display("FAIL mid_no_valid: got %0d valids, required %0d", valid_cnt, v0); else passed++;
    drive_req(8'h2A, 2, 1'b1);
    wait_drain(ok);
    checks++; if (!ok || {hundreds, tens, ones} !== 12'h042) $display("FAIL mid_fresh: got %h, required 042", {hundreds, tens, ones}); else passed++;
  endtask

  task automatic test_random;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      drive_req(8'($urandom_range(0, 255)), int'($urandom_range(1, 4)), 1'b1);
      wait_drain(ok);
      checks++; if (!ok) $display("FAIL rand_drain_%0d: got timeout, required completion", i); else passed++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, required end of run");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; done = 1'b0; product = 8'h00;
    @(negedge clk);
    test_reset;
    test_basic;
    test_sequence;
    test_done_held;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    test_random;
    repeat (5) @(negedge clk);
    checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
